// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory line port between I-cache and D-cache,
// latching the granted request and holding it on the memory side until mem_resp.
module cache_arbiter #(
   parameter int LINE_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic                  last_d_q, last_d_d;
   logic                  i_req, d_req, grant_d, serving;

   assign i_req   = i_pmem_read;
   assign d_req   = d_pmem_read | d_pmem_write;
   // D takes a tie unless round-robin says the I-cache is owed the turn
   assign grant_d = d_req & (~i_req | ~ROUND_ROBIN | ~last_d_q);
   assign serving = (state_q == SERVE_I) | (state_q == SERVE_D);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      last_d_d = last_d_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d  = SERVE_D;
               addr_d   = d_pmem_address;
               wdata_d  = d_pmem_wdata;
               write_d  = d_pmem_write;
               last_d_d = 1'b1;
            end else if (i_req) begin
               state_d  = SERVE_I;
               addr_d   = i_pmem_address;
               write_d  = 1'b0;
               last_d_d = 1'b0;
            end
         end
         SERVE_I, SERVE_D: state_d = mem_resp ? RELEASE : state_q;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         last_d_q <= last_d_d;
      end
   end

   assign mem_read     = serving & ~write_q;
   assign mem_write    = serving & write_q;
   assign mem_address  = addr_q;
   assign mem_wdata    = wdata_q;
   assign i_pmem_rdata = mem_rdata;
   assign d_pmem_rdata = mem_rdata;
   assign i_pmem_resp  = mem_resp & (state_q == SERVE_I);
   assign d_pmem_resp  = mem_resp & (state_q == SERVE_D);

   a_rw_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write))
      else $error("mem_read and mem_write high together");
   a_resp_excl: assert property (@(posedge clk) disable iff (rst) !(i_pmem_resp && d_pmem_resp))
      else $error("both cache responses high together");
   a_addr_stable: assert property (@(posedge clk) disable iff (rst) serving && $past(serving) |-> addr_q == $past(addr_q))
      else $error("addr_q changed during service");
   a_no_rdwr: assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write))
      else $error("d_pmem_read and d_pmem_write high together");
endmodule
